// File: rtl/rob_entry_multi_pkg.sv
// rob_pkg: shared definitions for the reorder-buffer entry slice.
//   - rob_state_t : entry life-cycle state encoding (IDLE/WAIT/END/EXC)
//   - field widths for the physical/logical register pointers and
//     exception code, plus the width of the optional perf counter
//     (compiled in with ROB_ENTRY_PERF_EN)
//   - rob_info_t  : the per-instruction fields cleared on commit
//   - idx_width() : index width for an N-way lowest-index encoder
package rob_pkg;

    typedef enum logic [1:0] {
        ROB_IDLE = 2'd0,
        ROB_WAIT = 2'd1,
        ROB_END  = 2'd2,
        ROB_EXC  = 2'd3
    } rob_state_t;

    localparam int FLAGS_PREG_W = 4;
    localparam int DEST_PREG_W  = 6;
    localparam int DEST_LREG_W  = 5;
    localparam int EXCODE_W     = 4;
    localparam int PERF_CNT_W   = 8;

    // Fields that a commit clears. PC and EX_BRANCH live outside this
    // struct because they survive a commit.
    typedef struct packed {
        logic                    make_flags;
        logic                    writeback;
        logic                    dest_sysreg;
        logic [FLAGS_PREG_W-1:0] flags_preg;
        logic [DEST_PREG_W-1:0]  dest_preg;
        logic [DEST_LREG_W-1:0]  dest_lreg;
    } rob_info_t;

    // A single-entry encoder still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rob_entry_multi_if.sv
// rob_entry_multi_if: dispatch / exec-end / commit bus of one ROB entry.
//   master : scheduler side, drives registration lanes, exec-end ports,
//            commit and restart; receives the entry's info outputs.
//   slave  : the entry itself (rob_entry_multi).
// With ROB_ENTRY_PERF_EN defined the bus also carries oINFO_EX_CYCLES.
interface rob_entry_multi_if
    import rob_pkg::*;
#(
    parameter int TAG_W        = 6,
    parameter int REGIST_SLOTS = 2,
    parameter int EXEND_PORTS  = 4,
    parameter int PC_W         = 32
);
    logic                                iLOCK;
    logic                                iRESTART_VALID;
    logic [TAG_W-1:0]                    iREGIST_POINTER;
    logic [REGIST_SLOTS-1:0]             iREGIST_VALID;
    logic [REGIST_SLOTS-1:0]             iREGIST_MAKE_FLAGS;
    logic [REGIST_SLOTS-1:0]             iREGIST_WRITEBACK;
    logic [FLAGS_PREG_W*REGIST_SLOTS-1:0] iREGIST_FLAGS_PREG;
    logic [DEST_PREG_W*REGIST_SLOTS-1:0] iREGIST_DEST_PREG;
    logic [DEST_LREG_W*REGIST_SLOTS-1:0] iREGIST_DEST_LREG;
    logic [REGIST_SLOTS-1:0]             iREGIST_DEST_SYSREG;
    logic [REGIST_SLOTS-1:0]             iREGIST_EX_BRANCH;
    logic [PC_W-1:0]                     iREGIST_PC;
    logic                                iCOMMIT_VALID;
    logic [EXEND_PORTS-1:0]              iEXEND_VALID;
    logic [TAG_W*EXEND_PORTS-1:0]        iEXEND_COMMIT_TAG;
    logic [EXEND_PORTS-1:0]              iEXEND_EXCEPTION;
    logic [EXCODE_W*EXEND_PORTS-1:0]     iEXEND_EXCODE;

    logic                                oINFO_VALID;
    logic                                oINFO_MAKE_FLAGS_VALID;
    logic                                oINFO_WRITEBACK_VALID;
    logic                                oINFO_DEST_SYSREG;
    logic                                oINFO_EX_BRANCH;
    logic [PC_W-1:0]                     oINFO_PC;
    logic [FLAGS_PREG_W-1:0]             oINFO_FLAGS_PREG_POINTER;
    logic [DEST_PREG_W-1:0]              oINFO_DEST_PREG_POINTER;
    logic [DEST_LREG_W-1:0]              oINFO_DEST_LREG_POINTER;
    logic                                oINFO_EX_END;
    logic                                oINFO_EXCEPTION;
    logic [EXCODE_W-1:0]                 oINFO_EXCODE;
    logic                                oINFO_FREE;
`ifdef ROB_ENTRY_PERF_EN
    logic [PERF_CNT_W-1:0]               oINFO_EX_CYCLES;
`endif

    modport master (
        output iLOCK, iRESTART_VALID, iREGIST_POINTER, iREGIST_VALID,
               iREGIST_MAKE_FLAGS, iREGIST_WRITEBACK, iREGIST_FLAGS_PREG,
               iREGIST_DEST_PREG, iREGIST_DEST_LREG, iREGIST_DEST_SYSREG,
               iREGIST_EX_BRANCH, iREGIST_PC, iCOMMIT_VALID, iEXEND_VALID,
               iEXEND_COMMIT_TAG, iEXEND_EXCEPTION, iEXEND_EXCODE,
        input  oINFO_VALID, oINFO_MAKE_FLAGS_VALID, oINFO_WRITEBACK_VALID,
               oINFO_DEST_SYSREG, oINFO_EX_BRANCH, oINFO_PC,
               oINFO_FLAGS_PREG_POINTER, oINFO_DEST_PREG_POINTER,
               oINFO_DEST_LREG_POINTER, oINFO_EX_END, oINFO_EXCEPTION,
               oINFO_EXCODE, oINFO_FREE
`ifdef ROB_ENTRY_PERF_EN
        , input oINFO_EX_CYCLES
`endif
    );

    modport slave (
        input  iLOCK, iRESTART_VALID, iREGIST_POINTER, iREGIST_VALID,
               iREGIST_MAKE_FLAGS, iREGIST_WRITEBACK, iREGIST_FLAGS_PREG,
               iREGIST_DEST_PREG, iREGIST_DEST_LREG, iREGIST_DEST_SYSREG,
               iREGIST_EX_BRANCH, iREGIST_PC, iCOMMIT_VALID, iEXEND_VALID,
               iEXEND_COMMIT_TAG, iEXEND_EXCEPTION, iEXEND_EXCODE,
        output oINFO_VALID, oINFO_MAKE_FLAGS_VALID, oINFO_WRITEBACK_VALID,
               oINFO_DEST_SYSREG, oINFO_EX_BRANCH, oINFO_PC,
               oINFO_FLAGS_PREG_POINTER, oINFO_DEST_PREG_POINTER,
               oINFO_DEST_LREG_POINTER, oINFO_EX_END, oINFO_EXCEPTION,
               oINFO_EXCODE, oINFO_FREE
`ifdef ROB_ENTRY_PERF_EN
        , output oINFO_EX_CYCLES
`endif
    );

endinterface

// File: rtl/rob_entry_multi_tag_match.sv
// rob_tag_match: lowest-index tag match encoder.
//   iVALID[N]          per-element valid
//   iTAG[N*TAG_W]      per-element tag, element i at [i*TAG_W +: TAG_W]
//   iMATCH_TAG[TAG_W]  tag to look for
//   oHIT               some valid element carries iMATCH_TAG
//   oINDEX             lowest such element (0 when no hit)
// Purely combinational.
module rob_tag_match
    import rob_pkg::*;
#(
    parameter int N     = 2,
    parameter int TAG_W = 6,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]       iVALID,
    input  logic [N*TAG_W-1:0] iTAG,
    input  logic [TAG_W-1:0]   iMATCH_TAG,
    output logic               oHIT,
    output logic [IDX_W-1:0]   oINDEX
);

    logic [N-1:0] hit_vec;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cmp
            assign hit_vec[gi] = iVALID[gi] && (iTAG[gi*TAG_W +: TAG_W] == iMATCH_TAG);
        end
    endgenerate

    // Scan from the top down so the last assignment is the lowest hit.
    always_comb begin
        oHIT   = 1'b0;
        oINDEX = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                oHIT   = 1'b1;
                oINDEX = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rob_entry_multi.sv
// rob_entry_multi: one commit-window slot of the scheduler1 commit stage.
//   iCLOCK, inRESET (asynchronous, active-low)
//   bus (rob_entry_multi_if.slave):
//     registration lanes  -> entry captures the lowest lane whose tag
//                            (pointer + lane) equals ENTRY_ID
//     exec-end ports      -> lowest matching port ends the instruction,
//                            normally (END) or with an exception (EXC)
//     commit / restart    -> release; restart also clears PC/EX_BRANCH
//     oINFO_*             -> registered view of the entry; only
//                            oINFO_FREE is combinational
// Optional: ROB_ENTRY_PERF_EN adds oINFO_EX_CYCLES, a saturating count of
// cycles spent waiting for execution.
module rob_entry_multi
    import rob_pkg::*;
#(
    parameter int ENTRY_ID     = 0,
    parameter int TAG_W        = 6,
    parameter int REGIST_SLOTS = 2,
    parameter int EXEND_PORTS  = 4,
    parameter int PC_W         = 32,
    parameter int PC_STEP      = 4
) (
    input  logic iCLOCK,
    input  logic inRESET,
    rob_entry_multi_if.slave bus
);

    localparam int               LANE_IDX_W = idx_width(REGIST_SLOTS);
    localparam int               PORT_IDX_W = idx_width(EXEND_PORTS);
    localparam logic [TAG_W-1:0] MY_TAG     = TAG_W'(ENTRY_ID);

    // Lane k carries tag pointer+k; the TAG_W-wide add wraps naturally.
    logic [REGIST_SLOTS*TAG_W-1:0] lane_tag;
    generate
        for (genvar gi = 0; gi < REGIST_SLOTS; gi++) begin : g_lane_tag
            assign lane_tag[gi*TAG_W +: TAG_W] = bus.iREGIST_POINTER + TAG_W'(gi);
        end
    endgenerate

    logic                  reg_hit;
    logic [LANE_IDX_W-1:0] reg_idx;
    logic                  ex_hit;
    logic [PORT_IDX_W-1:0] ex_idx;

    rob_tag_match #(
        .N     (REGIST_SLOTS),
        .TAG_W (TAG_W),
        .IDX_W (LANE_IDX_W)
    ) u_reg_match (
        .iVALID     (bus.iREGIST_VALID),
        .iTAG       (lane_tag),
        .iMATCH_TAG (MY_TAG),
        .oHIT       (reg_hit),
        .oINDEX     (reg_idx)
    );

    rob_tag_match #(
        .N     (EXEND_PORTS),
        .TAG_W (TAG_W),
        .IDX_W (PORT_IDX_W)
    ) u_exend_match (
        .iVALID     (bus.iEXEND_VALID),
        .iTAG       (bus.iEXEND_COMMIT_TAG),
        .iMATCH_TAG (MY_TAG),
        .oHIT       (ex_hit),
        .oINDEX     (ex_idx)
    );

    rob_state_t            state_q,  state_d;
    rob_info_t             info_q,   info_d;
    logic [PC_W-1:0]       pc_q,     pc_d;
    logic                  branch_q, branch_d;
    logic [EXCODE_W-1:0]   excode_q, excode_d;
`ifdef ROB_ENTRY_PERF_EN
    logic [PERF_CNT_W-1:0] cycles_q, cycles_d;
`endif

    // Fields of the selected dispatch lane / exec-end port.
    rob_info_t           lane_info;
    logic [EXCODE_W-1:0] port_excode;
    int                  lane_i;
    int                  port_i;

    always_comb begin
        lane_i                 = int'(reg_idx);
        port_i                 = int'(ex_idx);
        lane_info.make_flags   = bus.iREGIST_MAKE_FLAGS[lane_i];
        lane_info.writeback    = bus.iREGIST_WRITEBACK[lane_i];
        lane_info.dest_sysreg  = bus.iREGIST_DEST_SYSREG[lane_i];
        lane_info.flags_preg   = bus.iREGIST_FLAGS_PREG[lane_i*FLAGS_PREG_W +: FLAGS_PREG_W];
        lane_info.dest_preg    = bus.iREGIST_DEST_PREG[lane_i*DEST_PREG_W +: DEST_PREG_W];
        lane_info.dest_lreg    = bus.iREGIST_DEST_LREG[lane_i*DEST_LREG_W +: DEST_LREG_W];
        port_excode            = bus.iEXEND_EXCODE[port_i*EXCODE_W +: EXCODE_W];
    end

    always_comb begin
        state_d  = state_q;
        info_d   = info_q;
        pc_d     = pc_q;
        branch_d = branch_q;
        excode_d = excode_q;
`ifdef ROB_ENTRY_PERF_EN
        cycles_d = cycles_q;
`endif
        if (bus.iRESTART_VALID) begin
            // Flush wins over anything else arriving in the same cycle.
            state_d  = ROB_IDLE;
            info_d   = '0;
            pc_d     = '0;
            branch_d = 1'b0;
            excode_d = '0;
`ifdef ROB_ENTRY_PERF_EN
            cycles_d = '0;
`endif
        end else begin
            case (state_q)
                ROB_IDLE: begin
                    if (!bus.iLOCK && reg_hit) begin
                        state_d  = ROB_WAIT;
                        info_d   = lane_info;
                        pc_d     = bus.iREGIST_PC + PC_W'(PC_STEP) * PC_W'(reg_idx);
                        branch_d = bus.iREGIST_EX_BRANCH[lane_i];
                        excode_d = '0;
`ifdef ROB_ENTRY_PERF_EN
                        cycles_d = '0;
`endif
                    end
                end
                ROB_WAIT: begin
`ifdef ROB_ENTRY_PERF_EN
                    if (cycles_q != {PERF_CNT_W{1'b1}}) begin
                        cycles_d = cycles_q + PERF_CNT_W'(1);
                    end
`endif
                    if (ex_hit) begin
                        if (bus.iEXEND_EXCEPTION[port_i]) begin
                            state_d  = ROB_EXC;
                            excode_d = port_excode;
                        end else begin
                            state_d  = ROB_END;
                        end
                    end
                end
                ROB_END, ROB_EXC: begin
                    // PC and EX_BRANCH stay visible after commit.
                    if (bus.iCOMMIT_VALID) begin
                        state_d  = ROB_IDLE;
                        info_d   = '0;
                        excode_d = '0;
`ifdef ROB_ENTRY_PERF_EN
                        cycles_d = '0;
`endif
                    end
                end
                default: state_d = ROB_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q  <= ROB_IDLE;
            info_q   <= '0;
            pc_q     <= '0;
            branch_q <= 1'b0;
            excode_q <= '0;
`ifdef ROB_ENTRY_PERF_EN
            cycles_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            info_q   <= info_d;
            pc_q     <= pc_d;
            branch_q <= branch_d;
            excode_q <= excode_d;
`ifdef ROB_ENTRY_PERF_EN
            cycles_q <= cycles_d;
`endif
        end
    end

    assign bus.oINFO_VALID              = (state_q != ROB_IDLE);
    assign bus.oINFO_EX_END             = (state_q == ROB_END) || (state_q == ROB_EXC);
    assign bus.oINFO_EXCEPTION          = (state_q == ROB_EXC);
    assign bus.oINFO_MAKE_FLAGS_VALID   = info_q.make_flags;
    assign bus.oINFO_WRITEBACK_VALID    = info_q.writeback;
    assign bus.oINFO_DEST_SYSREG        = info_q.dest_sysreg;
    assign bus.oINFO_FLAGS_PREG_POINTER = info_q.flags_preg;
    assign bus.oINFO_DEST_PREG_POINTER  = info_q.dest_preg;
    assign bus.oINFO_DEST_LREG_POINTER  = info_q.dest_lreg;
    assign bus.oINFO_EX_BRANCH          = branch_q;
    assign bus.oINFO_PC                 = pc_q;
    assign bus.oINFO_EXCODE             = excode_q;
    assign bus.oINFO_FREE               = bus.iRESTART_VALID && (state_q != ROB_IDLE);
`ifdef ROB_ENTRY_PERF_EN
    assign bus.oINFO_EX_CYCLES          = cycles_q;
`endif

endmodule
